icache_fetch: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction fetch queue's memory request/response port and the main memory bus.
- Serves hits with one-cycle latency, back-to-back.
- On a miss, refills a whole line with sequential single-word reads, then returns the requested word tagged with its address.
- Supports a full invalidate for fence.i.

---
 rtl/icache_fetch.sv | 151 +++++++++++++++
 tb/tb_icache_fetch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: one-cycle hits, word-by-word line refill on a miss,
// full invalidate for fence.i.
module icache_fetch #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ireq_valid,
  output logic        ireq_ready,
  input  logic [31:0] ireq_addr,
  output logic        iresp_valid,
  output logic [31:0] iresp_addr,
  output logic [31:0] iresp_inst,
  input  logic        invalidate,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = 30 - OffW - IdxW;

  typedef enum logic [1:0] {StIdle, StRefillReq, StRefillWait, StRespond} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [OffW-1:0]      cnt_q, cnt_d;
  logic                 kill_q, kill_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 iresp_valid_q, iresp_valid_d;
  logic [31:0]          iresp_addr_q, iresp_addr_d;
  logic [31:0]          iresp_inst_q, iresp_inst_d;

  logic [TagW-1:0]      tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  logic [OffW-1:0] req_off, miss_off;
  logic [IdxW-1:0] req_idx, miss_idx;
  logic [TagW-1:0] req_tag, miss_tag;
  logic            req_hit, accept, data_we, last_word;

  assign req_off  = ireq_addr[2 +: OffW];
  assign req_idx  = ireq_addr[2+OffW +: IdxW];
  assign req_tag  = ireq_addr[31 -: TagW];
  assign miss_off = addr_q[2 +: OffW];
  assign miss_idx = addr_q[2+OffW +: IdxW];
  assign miss_tag = addr_q[31 -: TagW];

  assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // Ready depends on state (and reset) only, never on ireq_valid.
  assign ireq_ready = rst_n && (state_q == StIdle);
  assign accept     = ireq_valid && ireq_ready;
  assign data_we    = (state_q == StRefillWait) && mem_resp_valid;
  assign last_word  = data_we && (cnt_q == OffW'(LINE_WORDS - 1));

  assign mem_req_valid = (state_q == StRefillReq);
  assign mem_req_addr  = mem_req_valid ? {addr_q[31:OffW+2], cnt_q, 2'b00} : '0;

  assign iresp_valid = iresp_valid_q;
  assign iresp_addr  = iresp_addr_q;
  assign iresp_inst  = iresp_inst_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    kill_d        = kill_q;
    valid_d       = valid_q;
    iresp_valid_d = 1'b0;
    iresp_addr_d  = iresp_addr_q;
    iresp_inst_d  = iresp_inst_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = ireq_addr;
          if (req_hit) begin
            iresp_valid_d = 1'b1;
            iresp_addr_d  = ireq_addr;
            iresp_inst_d  = data_q[{req_idx, req_off}];
          end else begin
            state_d          = StRefillReq;
            cnt_d            = '0;
            valid_d[req_idx] = 1'b0;
          end
        end
      end
      StRefillReq: begin
        if (mem_req_ready) state_d = StRefillWait;
      end
      StRefillWait: begin
        if (mem_resp_valid) begin
          cnt_d = cnt_q + OffW'(1);
          if (last_word) begin
            state_d       = StRespond;
            iresp_valid_d = 1'b1;
            iresp_addr_d  = addr_q;
            // The requested word may be the one arriving right now.
            iresp_inst_d  = (miss_off == cnt_q) ? mem_resp_data : data_q[{miss_idx, miss_off}];
          end else begin
            state_d = StRefillReq;
          end
        end
      end
      StRespond: begin
        state_d = StIdle;
        kill_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (invalidate) begin
      valid_d = '0;
      if (state_q == StRefillReq || state_q == StRefillWait) kill_d = 1'b1;
    end
    if (last_word && !kill_q && !invalidate) valid_d[miss_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      cnt_q         <= '0;
      kill_q        <= 1'b0;
      valid_q       <= '0;
      iresp_valid_q <= 1'b0;
      iresp_addr_q  <= '0;
      iresp_inst_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      kill_q        <= kill_d;
      valid_q       <= valid_d;
      iresp_valid_q <= iresp_valid_d;
      iresp_addr_q  <= iresp_addr_d;
      iresp_inst_q  <= iresp_inst_d;
    end
  end

  // Array contents need no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (data_we)   data_q[{miss_idx, cnt_q}] <= mem_resp_data;
    if (last_word) tag_q[miss_idx]           <= miss_tag;
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed vector table, multi-cycle corner sequences and a randomized
// run checked against a line-level cache model.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq_valid, ireq_ready;
  logic [31:0] ireq_addr;
  logic        iresp_valid;
  logic [31:0] iresp_addr, iresp_inst;
  logic        invalidate;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  icache_fetch #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ireq_valid    (ireq_valid),
    .ireq_ready    (ireq_ready),
    .ireq_addr     (ireq_addr),
    .iresp_valid   (iresp_valid),
    .iresp_addr    (iresp_addr),
    .iresp_inst    (iresp_inst),
    .invalidate    (invalidate),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {logic [31:0] addr; logic [31:0] inst;} resp_t;
  typedef struct {logic [31:0] addr; bit inval; bit hit; logic [31:0] inst;} vec_t;

  resp_t       exp_q[$];
  logic [31:0] mem_log[$];
  int          resp_count = 0;
  int          n_exp = 0;
  bit          hs_seen = 0;
  logic [31:0] hs_addr = '0;
  bit          stall_force = 0;
  bit          stray_req = 0;
  int          wait_cnt = 0;
  logic [31:0] resp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Backing memory: line 0x100 holds 0xA0..0xA3, everything else is address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {28'h0, a[3:2]};
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Response scoreboard and memory-request log, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    resp_t r;
    hs_seen = rst_n && mem_req_valid && mem_req_ready;
    if (hs_seen) begin
      hs_addr = mem_req_addr;
      mem_log.push_back(mem_req_addr);
    end
    if (iresp_valid) begin
      resp_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_iresp: got pulse addr 0x%08h, want no pulse", iresp_addr);
      end else begin
        r = exp_q.pop_front();
        check("iresp_addr", iresp_addr, r.addr);
        check("iresp_inst", iresp_inst, r.inst);
      end
    end
  end

  // Memory: random ready, 1-3 cycle read latency, at most one read outstanding.
  always @(posedge clk) begin
    #1;
    mem_resp_valid = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
    end else begin
      if (stray_req) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        stray_req      = 0;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(resp_addr);
        end
      end
      if (hs_seen) begin
        wait_cnt  = int'($urandom_range(1, 3));
        resp_addr = hs_addr;
      end
    end
    mem_req_ready = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic wait_ready();
    int t = 0;
    while (!ireq_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ireq_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ireq_ready 0, want 1");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] inst);
    wait_ready();
    ireq_valid = 1'b1;
    ireq_addr  = a;
    exp_q.push_back('{a, inst});
    n_exp++;
    @(negedge clk);
    ireq_valid = 1'b0;
  endtask

  task automatic finish_req(input string name, input bit hit, input logic [31:0] a);
    int t = 0;
    while (resp_count < n_exp && t < 300) begin
      if (!hit) check({name, "_ready_low"}, {31'b0, ireq_ready}, 32'd0);
      @(negedge clk);
      t++;
    end
    check({name, "_resp_count"}, resp_count, n_exp);
    check({name, "_mem_reads"}, mem_log.size(), hit ? 0 : 4);
    if (!hit && mem_log.size() == 4)
      for (int i = 0; i < 4; i++)
        check({name, "_read_addr"}, mem_log[i], {a[31:4], 4'b0} + 32'(4 * i));
    mem_log.delete();
  endtask

  task automatic pulse_inval();
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
  endtask

  vec_t        vt[8];
  bit          mv[16];
  logic [31:0] mt[16];

  initial begin
    vt[0] = '{32'h100, 0, 0, 32'h0000_00A0};
    vt[1] = '{32'h103, 0, 1, 32'h0000_00A0};
    vt[2] = '{32'h200, 0, 0, 32'hBCEF_0200};
    vt[3] = '{32'h100, 0, 0, 32'h0000_00A0};
    vt[4] = '{32'h10C, 0, 1, 32'h0000_00A3};
    vt[5] = '{32'h100, 1, 0, 32'h0000_00A0};
    vt[6] = '{32'h20C, 0, 0, 32'hBCE3_020C};
    vt[7] = '{32'h100, 0, 0, 32'h0000_00A0};

    rst_n = 1'b0; ireq_valid = 1'b0; ireq_addr = '0; invalidate = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    #12;
    check("rst_ireq_ready", {31'b0, ireq_ready}, 32'd0);
    check("rst_iresp_valid", {31'b0, iresp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_iresp_addr", iresp_addr, 32'd0);
    check("rst_iresp_inst", iresp_inst, 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].inval) begin
        wait_ready();
        pulse_inval();
      end
      issue(vt[i].addr, vt[i].inst);
      finish_req($sformatf("vec%0d", i), vt[i].hit, vt[i].addr);
    end

    // Back-to-back hits on the cached 0x100 line.
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      ireq_valid = 1'b1;
      ireq_addr  = 32'h104 + 32'(4 * i);
      exp_q.push_back('{32'h104 + 32'(4 * i), 32'hA1 + 32'(i)});
      n_exp++;
      @(negedge clk);
      check("b2b_valid", {31'b0, iresp_valid}, 32'd1);
    end
    ireq_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle_valid", {31'b0, iresp_valid}, 32'd0);
    check("b2b_hold_addr", iresp_addr, 32'h10C);
    check("b2b_resp_count", resp_count, n_exp);
    check("b2b_mem_reads", mem_log.size(), 0);

    // Invalidate while the refill of 0x300 waits on memory.
    issue(32'h300, 32'hBDEF_0300);
    begin
      int t = 0;
      while (!(mem_log.size() >= 1 && !mem_req_valid) && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    pulse_inval();
    finish_req("inval_refill", 0, 32'h300);
    issue(32'h300, 32'hBDEF_0300);
    finish_req("inval_rerequest", 0, 32'h300);

    // Memory backpressure, then reset in the middle of the refill.
    wait_ready();
    stall_force = 1;
    @(negedge clk);
    issue(32'h400, 32'hBAEF_0400);
    for (int k = 0; k < 5; k++) begin
      check("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("stall_req_addr", mem_req_addr, 32'h400);
      @(negedge clk);
    end
    stall_force = 0;
    begin
      int t = 0;
      while (mem_log.size() < 2 && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    rst_n = 1'b0;
    exp_q.delete();
    n_exp = resp_count;
    #1;
    check("midrst_ireq_ready", {31'b0, ireq_ready}, 32'd0);
    check("midrst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("midrst_iresp_valid", {31'b0, iresp_valid}, 32'd0);
    @(negedge clk);
    mem_log.delete();
    rst_n = 1'b1;
    stray_req = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stray_iresp_valid", {31'b0, iresp_valid}, 32'd0);
      check("stray_ireq_ready", {31'b0, ireq_ready}, 32'd1);
    end
    check("stray_mem_reads", mem_log.size(), 0);
    issue(32'h400, 32'hBAEF_0400);
    finish_req("post_rst_400", 0, 32'h400);
    issue(32'h100, 32'hA0);
    finish_req("post_rst_100", 0, 32'h100);

    // Randomized run against the line model.
    wait_ready();
    pulse_inval();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    for (int r = 0; r < 80; r++) begin
      logic [31:0] a;
      int          idx;
      logic [31:0] tag;
      bit          hit;
      if ($urandom_range(0, 9) == 0) begin
        wait_ready();
        pulse_inval();
        for (int i = 0; i < 16; i++) mv[i] = 0;
      end
      a   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
            32'($urandom_range(0, 15));
      idx = int'((a >> 4) % 16);
      tag = a >> 8;
      hit = mv[idx] && (mt[idx] == tag);
      issue(a, mem_word(a & ~32'h3));
      finish_req("rand", hit, a);
      mv[idx] = 1;
      mt[idx] = tag;
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
